// File: rtl/alu_pkg.sv
// ============================================================================
//  Module : alu_pkg
//  Brief  : Shared FSM state encoding and parameter legality helper for the
//           chunked adder/subtractor.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (width >= 2) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_chunk.sv
// ============================================================================
//  Module : adder_chunk
//  Brief  : Combinational CHUNK-bit ripple adder built from full_adder cells.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_c,
    input  logic [CHUNK-1:0] b_c,
    input  logic             cin,
    output logic [CHUNK-1:0] s_c,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar i = 0; i < CHUNK; i++) begin : g_bit
            full_adder u_fa (
                .a    (a_c[i]),
                .b    (b_c[i]),
                .cin  (w_carry[i]),
                .s    (s_c[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    assign cout     = w_carry[CHUNK];
    // Carry into the top bit; XOR with cout gives signed overflow on the last chunk.
    assign c_msb_in = w_carry[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
//  Module : full_adder
//  Brief  : Single-bit full adder cell.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/chunked_addsub.sv
// ============================================================================
//  Module : chunked_addsub
//  Brief  : Multi-cycle two's-complement add/sub, CHUNK bits per clock, LS
//           chunk first, with valid/ready handshakes on input and output.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module chunked_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             zero,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    generate
        if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
            $error("chunked_addsub: illegal WIDTH/CHUNK combination");
        end
    endgenerate

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               carryout_q,  carryout_d;
    logic               overflow_q,  overflow_d;
    logic               zero_q,      zero_d;
    logic               out_valid_q, out_valid_d;

    int unsigned        w_base;
    logic [CHUNK-1:0]   w_a_c;
    logic [CHUNK-1:0]   w_b_c;
    logic [CHUNK-1:0]   w_s_c;
    logic               w_cout;
    logic               w_c_msb;
    logic               w_last;

    assign w_base = 32'(cnt_q) * CHUNK;
    assign w_a_c  = a_q[w_base +: CHUNK];
    assign w_b_c  = b_q[w_base +: CHUNK];
    assign w_last = (cnt_q == CNT_W'(NCHUNK - 1));

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_adder_chunk (
        .a_c      (w_a_c),
        .b_c      (w_b_c),
        .cin      (carry_q),
        .s_c      (w_s_c),
        .cout     (w_cout),
        .c_msb_in (w_c_msb)
    );

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                    state_d    = RUN;
                    a_d        = a;
                    b_d        = b ^ {WIDTH{sub}};
                    carry_d    = sub;
                    cnt_d      = '0;
                    sum_d      = '0;
                    carryout_d = 1'b0;
                    overflow_d = 1'b0;
                    zero_d     = 1'b0;
                end
            end
            RUN: begin
                sum_d[w_base +: CHUNK] = w_s_c;
                carry_d                = w_cout;
                if (w_last) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    out_valid_d = 1'b1;
                    carryout_d  = w_cout;
                    overflow_d  = w_c_msb ^ w_cout;
                    zero_d      = (sum_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_chunked_addsub.sv
// ============================================================================
//  Module : tb_chunked_addsub
//  Brief  : Self-checking bench for chunked_addsub (WIDTH=8, CHUNK=2/1/8).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_chunked_addsub;

    logic       clk;
    logic       rst_n;
    logic       in_valid_s  [3];
    logic       in_ready_s  [3];
    logic [7:0] a_s         [3];
    logic [7:0] b_s         [3];
    logic       sub_s       [3];
    logic       out_valid_s [3];
    logic       out_ready_s [3];
    logic [7:0] sum_s       [3];
    logic       carryout_s  [3];
    logic       overflow_s  [3];
    logic       zero_s      [3];
    logic       busy_s      [3];

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    chunked_addsub #(.WIDTH(8), .CHUNK(2)) u_dut_c2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .sub(sub_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]), .sum(sum_s[0]), .carryout(carryout_s[0]),
        .overflow(overflow_s[0]), .zero(zero_s[0]), .busy(busy_s[0])
    );

    chunked_addsub #(.WIDTH(8), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1]), .b(b_s[1]), .sub(sub_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]), .sum(sum_s[1]), .carryout(carryout_s[1]),
        .overflow(overflow_s[1]), .zero(zero_s[1]), .busy(busy_s[1])
    );

    chunked_addsub #(.WIDTH(8), .CHUNK(8)) u_dut_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2]), .b(b_s[2]), .sub(sub_s[2]), .out_valid(out_valid_s[2]),
        .out_ready(out_ready_s[2]), .sum(sum_s[2]), .carryout(carryout_s[2]),
        .overflow(overflow_s[2]), .zero(zero_s[2]), .busy(busy_s[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] e_sum, output logic e_c,
                         output logic e_ov, output logic e_z);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = s ? (ua - ub) : (ua + ub);
        sr = s ? (sa - sb) : (sa + sb);
        e_sum = ur[7:0];
        e_c   = s ? (ua >= ub) : (ur >= 256);
        e_ov  = (sr > 127) || (sr < -128);
        e_z   = (e_sum == 8'h00);
    endtask

    // Called at a negedge with the block idle; returns at a negedge with it idle again.
    task automatic run_op(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input int nchunk, input int hold);
        logic [7:0] e_sum;
        logic       e_c, e_ov, e_z;
        int         lat;
        model(a, b, s, e_sum, e_c, e_ov, e_z);
        chk("in_ready_idle", 32'(in_ready_s[idx]), 32'd1);
        in_valid_s[idx]  = 1'b1;
        a_s[idx]         = a;
        b_s[idx]         = b;
        sub_s[idx]       = s;
        out_ready_s[idx] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[idx] = 1'b0;
        a_s[idx]        = 8'($urandom);
        b_s[idx]        = 8'($urandom);
        sub_s[idx]      = 1'($urandom);
        chk("busy_after_accept", 32'(busy_s[idx]), 32'd1);
        chk("in_ready_after_accept", 32'(in_ready_s[idx]), 32'd0);
        lat = 0;
        while (!out_valid_s[idx] && lat < 64) begin
            @(negedge clk);
            lat++;
            if (lat < nchunk) chk("busy_in_run", 32'(busy_s[idx]), 32'd1);
        end
        chk("latency", 32'(lat), 32'(nchunk));
        chk("sum", 32'(sum_s[idx]), 32'(e_sum));
        chk("carryout", 32'(carryout_s[idx]), 32'(e_c));
        chk("overflow", 32'(overflow_s[idx]), 32'(e_ov));
        chk("zero", 32'(zero_s[idx]), 32'(e_z));
        chk("busy_done", 32'(busy_s[idx]), 32'd1);
        for (int i = 0; i < hold; i++) begin
            in_valid_s[idx] = (i == 1);
            a_s[idx]        = 8'($urandom);
            b_s[idx]        = 8'($urandom);
            sub_s[idx]      = 1'($urandom);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid_s[idx]), 32'd1);
            chk("hold_in_ready", 32'(in_ready_s[idx]), 32'd0);
            chk("hold_sum", 32'(sum_s[idx]), 32'(e_sum));
            chk("hold_flags", {29'd0, carryout_s[idx], overflow_s[idx], zero_s[idx]},
                {29'd0, e_c, e_ov, e_z});
        end
        in_valid_s[idx]  = 1'b0;
        out_ready_s[idx] = 1'b1;
        @(negedge clk);
        out_ready_s[idx] = 1'b0;
        chk("out_valid_drop", 32'(out_valid_s[idx]), 32'd0);
        chk("in_ready_back", 32'(in_ready_s[idx]), 32'd1);
        chk("busy_back", 32'(busy_s[idx]), 32'd0);
        chk("sum_kept", 32'(sum_s[idx]), 32'(e_sum));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_s[i]  = 1'b0;
            a_s[i]         = 8'h00;
            b_s[i]         = 8'h00;
            sub_s[i]       = 1'b0;
            out_ready_s[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_sum", 32'(sum_s[i]), 32'd0);
            chk("rst_flags", {28'd0, carryout_s[i], overflow_s[i], zero_s[i], out_valid_s[i]}, 32'd0);
            chk("rst_in_ready", 32'(in_ready_s[i]), 32'd1);
            chk("rst_busy", 32'(busy_s[i]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, CHUNK=2
        run_op(0, 8'h7F, 8'h01, 1'b0, 4, 0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 4, 0);
        run_op(0, 8'h05, 8'h07, 1'b1, 4, 0);
        run_op(0, 8'h80, 8'h01, 1'b1, 4, 0);
        // Backpressure with a stray in_valid pulse, then a normal op
        run_op(0, 8'h3C, 8'hC4, 1'b0, 4, 5);
        run_op(0, 8'h12, 8'h34, 1'b1, 4, 0);

        // Reset two cycles into RUN
        in_valid_s[0] = 1'b1;
        a_s[0]        = 8'h33;
        b_s[0]        = 8'h44;
        sub_s[0]      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_s[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_sum", 32'(sum_s[0]), 32'd0);
        chk("midrst_flags", {28'd0, carryout_s[0], overflow_s[0], zero_s[0], out_valid_s[0]}, 32'd0);
        chk("midrst_in_ready", 32'(in_ready_s[0]), 32'd1);
        chk("midrst_busy", 32'(busy_s[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 8'h10, 8'h20, 1'b0, 4, 0);

        // Random sweep, bit-serial and single-cycle configurations
        for (int n = 0; n < 1000; n++)
            run_op(1, 8'($urandom), 8'($urandom), 1'($urandom), 8, 0);
        for (int n = 0; n < 1000; n++)
            run_op(2, 8'($urandom), 8'($urandom), 1'($urandom), 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
